// File: rtl/mssd_serial_tx.sv
// ============================================================================
// Module   : mssd_serial_tx
// Purpose  : Frame serializer feeding the serial message decoder, MSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mssd_serial_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  pn,
    input  logic [3:0]  len,
    input  logic [14:0] data,
    output logic        sout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PORT  = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  nbits_q, nbits_d;
    logic        sout_q, sout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [14:0] data_aligned;
    logic [20:0] shreg_shifted;

    // Left-justify the payload so data[n-1] lands on the shift-out end.
    assign data_aligned  = data << (4'd15 - len);
    assign shreg_shifted = {shreg_q[19:0], 1'b0};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_START;
                    sout_d  = 1'b0;
                    busy_d  = 1'b1;
                    shreg_d = {pn, len, data_aligned};
                    nbits_d = len;
                    cnt_d   = 4'd0;
                end
            end
            S_START: begin
                state_d = S_PORT;
                cnt_d   = 4'd1;
                sout_d  = shreg_q[20];
                shreg_d = shreg_shifted;
            end
            S_PORT: begin
                sout_d  = shreg_q[20];
                shreg_d = shreg_shifted;
                if (cnt_q == 4'd0) begin
                    state_d = S_LEN;
                    cnt_d   = 4'd3;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_LEN: begin
                if (cnt_q != 4'd0) begin
                    sout_d  = shreg_q[20];
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q - 4'd1;
                end else if (nbits_q != 4'd0) begin
                    state_d = S_DATA;
                    sout_d  = shreg_q[20];
                    shreg_d = shreg_shifted;
                    cnt_d   = nbits_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q != 4'd0) begin
                    sout_d  = shreg_q[20];
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= 21'd0;
            cnt_q   <= 4'd0;
            nbits_q <= 4'd0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mssd_serial_tx.sv
// ============================================================================
// Module   : tb_mssd_serial_tx
// Purpose  : Self-checking bench for mssd_serial_tx with a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mssd_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pn = 2'd0;
    logic [3:0]  len = 4'd0;
    logic [14:0] data = 15'd0;
    logic        sout, busy, done;

    int vectors = 0;
    int miscompares = 0;
    bit exp_bits[$];

    mssd_serial_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pn    (pn),
        .len   (len),
        .data  (data),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference frame: start 0, pn MSB first, len MSB first, data[n-1]..data[0].
    function automatic void build_frame(input logic [1:0] p, input logic [3:0] l,
                                        input logic [14:0] d);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 1; i >= 0; i--) exp_bits.push_back(p[i]);
        for (int i = 3; i >= 0; i--) exp_bits.push_back(l[i]);
        for (int i = int'(l) - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_hold: sout/busy/done=%b%b%b expected 100", sout, busy, done);
            end
        end
        @(negedge clk); rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_idle: sout/busy/done=%b%b%b expected 100", sout, busy, done);
            end
        end
    endtask

    task automatic test_basic;
        logic [9:0] seq;
        seq = 10'b0100011101;
        @(negedge clk); pn = 2'b10; len = 4'd3; data = 15'b101; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (sout !== seq[9-i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_bit%0d: sout=%b busy=%b done=%b expected sout=%b busy=1 done=0",
                         i, sout, busy, done, seq[9-i]);
            end
            @(negedge clk); start = 1'b0;
        end
        @(posedge clk); #1;
        vectors++;
        if ({sout, busy, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL basic_done: sout/busy/done=%b%b%b expected 101", sout, busy, done);
        end
        @(posedge clk); #1;
        vectors++;
        if ({sout, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_after: sout/busy/done=%b%b%b expected 100", sout, busy, done);
        end
    endtask

    task automatic test_zero_len;
        logic [6:0] seq;
        seq = 7'b0010000;
        @(negedge clk); pn = 2'b01; len = 4'd0; data = 15'h7fff; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (sout !== seq[6-i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len_bit%0d: sout=%b busy=%b done=%b expected sout=%b busy=1 done=0",
                         i, sout, busy, done, seq[6-i]);
            end
            @(negedge clk); start = 1'b0;
        end
        @(posedge clk); #1;
        vectors++;
        if ({sout, busy, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL zero_len_done: sout/busy/done=%b%b%b expected 101", sout, busy, done);
        end
    endtask

    task automatic test_ignored_start;
        build_frame(2'b01, 4'd5, 15'h0015);
        @(negedge clk); pn = 2'b01; len = 4'd5; data = 15'h0015; start = 1'b1;
        for (int i = 0; i < exp_bits.size(); i++) begin
            @(posedge clk); #1;
            vectors++;
            if (sout !== exp_bits[i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_bit%0d: sout=%b busy=%b done=%b expected sout=%b busy=1 done=0",
                         i, sout, busy, done, exp_bits[i]);
            end
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin pn = 2'b10; len = 4'd15; data = 15'h7fff; end
        end
        @(posedge clk); #1;
        vectors++;
        if ({sout, busy, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL ignored_done: sout/busy/done=%b%b%b expected 101", sout, busy, done);
        end
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL ignored_no_requeue: sout/busy/done=%b%b%b expected 100", sout, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit es[18] = '{0,1,1,0,0,0,1,1, 1, 0,0,0,0,0,0,0, 1, 1};
        bit eb[18] = '{1,1,1,1,1,1,1,1, 0, 1,1,1,1,1,1,1, 0, 0};
        bit ed[18] = '{0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0, 1, 0};
        @(negedge clk); pn = 2'b11; len = 4'd1; data = 15'd1; start = 1'b1;
        for (int j = 0; j < 18; j++) begin
            @(posedge clk); #1;
            vectors++;
            if (sout !== es[j] || busy !== eb[j] || done !== ed[j]) begin
                miscompares++;
                $display("FAIL b2b_step%0d: sout/busy/done=%b%b%b expected %b%b%b",
                         j, sout, busy, done, es[j], eb[j], ed[j]);
            end
            @(negedge clk);
            if (j == 3) begin pn = 2'b00; len = 4'd0; data = 15'd0; end
            if (j == 9) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [1:0]  p;
        logic [3:0]  l;
        logic [14:0] d;
        @(negedge clk); pn = 2'b10; len = 4'd9; data = 15'h2a5c; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({sout, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL async_reset: sout/busy/done=%b%b%b expected 100", sout, busy, done);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_no_done: sout/busy/done=%b%b%b expected 100", sout, busy, done);
            end
        end
        p = 2'($urandom); l = 4'($urandom); d = 15'($urandom);
        build_frame(p, l, d);
        @(negedge clk); pn = p; len = l; data = d; start = 1'b1;
        for (int i = 0; i < exp_bits.size(); i++) begin
            @(posedge clk); #1;
            vectors++;
            if (sout !== exp_bits[i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_bit%0d: sout=%b busy=%b done=%b expected sout=%b",
                         i, sout, busy, done, exp_bits[i]);
            end
            @(negedge clk); start = 1'b0;
        end
        @(posedge clk); #1;
        vectors++;
        if ({sout, busy, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL post_reset_done: sout/busy/done=%b%b%b expected 101", sout, busy, done);
        end
    endtask

    task automatic test_random;
        logic [1:0]  p;
        logic [3:0]  l;
        logic [14:0] d;
        for (int f = 0; f < 40; f++) begin
            p = 2'($urandom); l = 4'($urandom); d = 15'($urandom);
            build_frame(p, l, d);
            @(negedge clk); pn = p; len = l; data = d; start = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b010) begin
                miscompares++;
                $display("FAIL rand%0d_accept: sout/busy/done=%b%b%b expected 010", f, sout, busy, done);
            end
            for (int i = 1; i <= 7 + int'(l); i++) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                pn = 2'($urandom); len = 4'($urandom); data = 15'($urandom);
                @(posedge clk); #1;
                vectors++;
                if (i < exp_bits.size()) begin
                    if (sout !== exp_bits[i] || busy !== 1'b1 || done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rand%0d_bit%0d: sout=%b busy=%b done=%b expected sout=%b busy=1 done=0",
                                 f, i, sout, busy, done, exp_bits[i]);
                    end
                end else if ({sout, busy, done} !== 3'b101) begin
                    miscompares++;
                    $display("FAIL rand%0d_done: sout/busy/done=%b%b%b expected 101", f, sout, busy, done);
                end
            end
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            vectors++;
            if ({sout, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL rand%0d_idle: sout/busy/done=%b%b%b expected 100", f, sout, busy, done);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
